// File: rtl/sd_filter_pkg.sv
// rtl/sd_filter_pkg.sv - shared types and helpers for the sigma-delta filter cascade
package sd_filter_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_RUN,
    SCHED_DONE
  } sd_sched_state_t;

  // One enable cycle per stage, plus the DONE cycle, plus the IDLE accept cycle.
  function automatic int min_sample_period(input int n_stages);
    return n_stages + 2;
  endfunction

endpackage

// File: rtl/sd_filter_sched_if.sv
// rtl/sd_filter_sched_if.sv - sample-in / stage-control-out bundle of the stage sequencer
interface sd_filter_sched_if #(
  parameter int SEL_W = 2
);

  logic             sample_valid;
  logic             sample_bit;
  logic             fb_bit;
  logic             ready;
  logic [SEL_W-1:0] stage_sel;
  logic             stage_enb;
  logic             stage_rsvd;
  logic             stage_fb;
  logic             frame_done;
  logic             dec_valid;
  logic             overrun;

  modport master (
    output sample_valid, sample_bit, fb_bit,
    input  ready, stage_sel, stage_enb, stage_rsvd, stage_fb,
    input  frame_done, dec_valid, overrun
  );

  modport slave (
    input  sample_valid, sample_bit, fb_bit,
    output ready, stage_sel, stage_enb, stage_rsvd, stage_fb,
    output frame_done, dec_valid, overrun
  );

endinterface

// File: rtl/sd_dec_counter.sv
// rtl/sd_dec_counter.sv - modulo-DEC counter with registered terminal-count pulse
module sd_dec_counter #(
  parameter int DEC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  output logic o_tc
);

  localparam int               CNT_W = (DEC > 1) ? $clog2(DEC) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tc;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tc   = r_tc;

  // o_tc rises on the cycle after the wrapping increment, aligned with the caller's registered strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_tc <= i_inc & w_wrap;
      if (i_inc) begin
        r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sd_filter_sched.sv
// rtl/sd_filter_sched.sv - walks one shared node datapath over all stages per sample, last stage first
module sd_filter_sched
  import sd_filter_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int DEC      = 16,
  parameter int SEL_W    = $clog2(N_STAGES)
) (
  input  logic                clk,
  input  logic                reset,
  sd_filter_sched_if.slave    bus
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_STAGES - 1);

  sd_sched_state_t  r_state;
  sd_sched_state_t  w_state_nxt;
  logic             r_ready;
  logic [SEL_W-1:0] r_sel;
  logic             r_enb;
  logic             r_rsvd;
  logic             r_fb;
  logic             r_done;
  logic             r_overrun;
  logic             w_accept;
  logic             w_last_stage;
  logic             w_dec_tc;

  assign w_accept     = (r_state == SCHED_IDLE) && bus.sample_valid;
  assign w_last_stage = (r_state == SCHED_RUN) && (r_sel == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCHED_IDLE: if (bus.sample_valid) w_state_nxt = SCHED_RUN;
      SCHED_RUN:  if (r_sel == '0)      w_state_nxt = SCHED_DONE;
      SCHED_DONE: w_state_nxt = SCHED_IDLE;
      default:    w_state_nxt = SCHED_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= SCHED_IDLE;
      r_ready   <= 1'b1;
      r_sel     <= SEL_LAST;
      r_enb     <= 1'b0;
      r_rsvd    <= 1'b0;
      r_fb      <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= (w_state_nxt == SCHED_IDLE);
      r_enb     <= (w_state_nxt == SCHED_RUN);
      r_done    <= (w_state_nxt == SCHED_DONE);
      r_overrun <= r_overrun | (bus.sample_valid && (r_state != SCHED_IDLE));
      if (w_accept) begin
        r_rsvd <= bus.sample_bit;
        r_fb   <= bus.fb_bit;
        r_sel  <= SEL_LAST;
      end else if (r_state == SCHED_RUN) begin
        r_sel <= (r_sel == '0) ? SEL_LAST : r_sel - SEL_W'(1);
      end
    end
  end

  sd_dec_counter #(
    .DEC (DEC)
  ) u_dec_counter (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_last_stage),
    .o_tc  (w_dec_tc)
  );

  assign bus.ready      = r_ready;
  assign bus.stage_sel  = r_sel;
  assign bus.stage_enb  = r_enb;
  assign bus.stage_rsvd = r_rsvd;
  assign bus.stage_fb   = r_fb;
  assign bus.frame_done = r_done;
  assign bus.dec_valid  = w_dec_tc;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_sd_filter_sched.sv
// tb/tb_sd_filter_sched.sv - directed bench for sd_filter_sched at (4 stages, DEC 16) and (2 stages, DEC 1)
module tb_sd_filter_sched;
  import sd_filter_pkg::*;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  sd_filter_sched_if #(.SEL_W(2)) bus4 ();
  sd_filter_sched_if #(.SEL_W(1)) bus2 ();

  sd_filter_sched #(.N_STAGES(4), .DEC(16)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  sd_filter_sched #(.N_STAGES(2), .DEC(1)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    do_reset();
    got = {bus4.ready, bus4.stage_enb, bus4.stage_sel, bus4.stage_rsvd, bus4.stage_fb,
           bus4.frame_done, bus4.dec_valid, bus4.overrun};
    total_cnt++;
    if (got !== 9'b1_0_11_0_0_0_0_0) $display("FAIL reset4 got=%b want=%b", got, 9'b101100000);
    else pass_cnt++;
    got = {2'b00, bus2.ready, bus2.stage_enb, bus2.stage_sel, bus2.stage_rsvd, bus2.stage_fb,
           bus2.frame_done, bus2.overrun};
    total_cnt++;
    if (got !== 9'b00_1_0_1_0_0_0_0) $display("FAIL reset2 got=%b want=%b", got, 9'b001010000);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [6:0] exp_v [1:6];
    logic [6:0] got;
    logic       side;
    exp_v[1] = 7'b0_1_11_1_0_0;
    exp_v[2] = 7'b0_1_10_1_0_0;
    exp_v[3] = 7'b0_1_01_1_0_0;
    exp_v[4] = 7'b0_1_00_1_0_0;
    exp_v[5] = 7'b0_0_11_1_0_1;
    exp_v[6] = 7'b1_0_11_1_0_0;
    side = 1'b0;
    do_reset();
    bus4.sample_bit   = 1'b1;
    bus4.fb_bit       = 1'b0;
    bus4.sample_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus4.sample_valid = 1'b0;
        bus4.sample_bit   = 1'b0;
        bus4.fb_bit       = 1'b1;
      end
      got = {bus4.ready, bus4.stage_enb, bus4.stage_sel, bus4.stage_rsvd, bus4.stage_fb,
             bus4.frame_done};
      side = side | bus4.dec_valid | bus4.overrun;
      total_cnt++;
      if (got !== exp_v[k]) $display("FAIL single_c%0d got=%b want=%b", k, got, exp_v[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (side !== 1'b0) $display("FAIL single_dec_ovr got=%b want=0", side);
    else pass_cnt++;
  endtask

  task automatic test_decimation();
    int         n_done;
    int         n_dec;
    logic [4:0] got;
    logic [4:0] want;
    n_done = 0;
    n_dec  = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus4.sample_bit   = i[0];
      bus4.fb_bit       = i[1];
      bus4.sample_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 1) bus4.sample_valid = 1'b0;
        if (bus4.frame_done) n_done++;
        if (bus4.dec_valid)  n_dec++;
        if (k == 1) begin
          got  = {bus4.stage_enb, bus4.stage_sel, bus4.stage_rsvd, bus4.stage_fb};
          want = {1'b1, 2'd3, i[0], i[1]};
          total_cnt++;
          if (got !== want) $display("FAIL dec_start%0d got=%b want=%b", i, got, want);
          else pass_cnt++;
        end
        if (k == 5) begin
          got  = {3'b000, bus4.frame_done, bus4.dec_valid};
          want = {3'b000, 1'b1, (i == 15)};
          total_cnt++;
          if (got !== want) $display("FAIL dec_frame%0d got=%b want=%b", i, got, want);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (n_done !== 16) $display("FAIL dec_done_count got=%0d want=16", n_done);
    else pass_cnt++;
    total_cnt++;
    if (n_dec !== 1) $display("FAIL dec_valid_count got=%0d want=1", n_dec);
    else pass_cnt++;
    total_cnt++;
    if (bus4.overrun !== 1'b0) $display("FAIL dec_overrun got=%b want=0", bus4.overrun);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    int         n_done;
    n_done = 0;
    do_reset();
    bus4.sample_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus4.sample_valid = 1'b0;
    end
    total_cnt++;
    if (bus4.ready !== 1'b1) $display("FAIL b2b_ready got=%b want=1", bus4.ready);
    else pass_cnt++;
    bus4.sample_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus4.sample_valid = 1'b0;
        got = {bus4.ready, bus4.stage_enb, bus4.stage_sel};
        total_cnt++;
        if (got !== 4'b0_1_11) $display("FAIL b2b_restart got=%b want=0111", got);
        else pass_cnt++;
      end
      if (bus4.frame_done) n_done++;
    end
    total_cnt++;
    if ({bus4.overrun, n_done[3:0]} !== 5'b0_0001)
      $display("FAIL b2b_ovr_done got=%b/%0d want=0/1", bus4.overrun, n_done);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int n_enb;
    int n_done;
    n_enb  = 0;
    n_done = 0;
    do_reset();
    bus4.sample_valid = 1'b1;
    @(negedge clk);
    bus4.sample_valid = 1'b0;
    n_enb += int'(bus4.stage_enb);
    @(negedge clk);
    n_enb += int'(bus4.stage_enb);
    total_cnt++;
    if (bus4.overrun !== 1'b0) $display("FAIL ovr_before got=%b want=0", bus4.overrun);
    else pass_cnt++;
    bus4.sample_valid = 1'b1;
    @(negedge clk);
    bus4.sample_valid = 1'b0;
    n_enb += int'(bus4.stage_enb);
    total_cnt++;
    if (bus4.overrun !== 1'b1) $display("FAIL ovr_set got=%b want=1", bus4.overrun);
    else pass_cnt++;
    for (int k = 4; k <= 12; k++) begin
      @(negedge clk);
      n_enb  += int'(bus4.stage_enb);
      n_done += int'(bus4.frame_done);
    end
    total_cnt++;
    if (n_enb !== 4) $display("FAIL ovr_enb_count got=%0d want=4", n_enb);
    else pass_cnt++;
    total_cnt++;
    if (n_done !== 1) $display("FAIL ovr_done_count got=%0d want=1", n_done);
    else pass_cnt++;
    total_cnt++;
    if (bus4.overrun !== 1'b1) $display("FAIL ovr_sticky got=%b want=1", bus4.overrun);
    else pass_cnt++;
  endtask

  task automatic test_reset_midpass();
    logic [4:0] got;
    int         n_enb;
    int         n_done;
    n_enb  = 0;
    n_done = 0;
    bus4.sample_valid = 1'b1;
    @(negedge clk);
    bus4.sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = {3'b000, bus4.stage_enb, bus4.stage_sel == 2'd1};
    total_cnt++;
    if (got !== 5'b00011) $display("FAIL mid_pre got=%b want=00011", got);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got = {bus4.ready, bus4.stage_enb, bus4.stage_sel, bus4.frame_done} ^ {4'b0000, bus4.overrun};
    total_cnt++;
    if ({bus4.ready, bus4.stage_enb, bus4.stage_sel, bus4.frame_done, bus4.overrun} !== 6'b1_0_11_0_0)
      $display("FAIL mid_after got=%b want=101100",
               {bus4.ready, bus4.stage_enb, bus4.stage_sel, bus4.frame_done, bus4.overrun});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus4.stage_enb, bus4.frame_done} !== 2'b00)
      $display("FAIL mid_quiet got=%b want=00", {bus4.stage_enb, bus4.frame_done});
    else pass_cnt++;
    bus4.sample_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus4.sample_valid = 1'b0;
      n_enb  += int'(bus4.stage_enb);
      n_done += int'(bus4.frame_done);
    end
    total_cnt++;
    if ({n_enb[3:0], n_done[3:0]} !== 8'h41)
      $display("FAIL mid_rerun got=%0d/%0d want=4/1", n_enb, n_done);
    else pass_cnt++;
  endtask

  task automatic test_dec1();
    logic [4:0] exp_v [1:4];
    logic [4:0] got;
    int         period;
    exp_v[1] = 5'b0_1_1_0_0;
    exp_v[2] = 5'b0_1_0_0_0;
    exp_v[3] = 5'b0_0_1_1_1;
    exp_v[4] = 5'b1_0_1_0_0;
    period = min_sample_period(2);
    do_reset();
    for (int f = 0; f < 2; f++) begin
      bus2.sample_valid = 1'b1;
      for (int k = 1; k <= period; k++) begin
        @(negedge clk);
        if (k == 1) bus2.sample_valid = 1'b0;
        got = {bus2.ready, bus2.stage_enb, bus2.stage_sel, bus2.frame_done, bus2.dec_valid};
        total_cnt++;
        if (got !== exp_v[k]) $display("FAIL dec1_f%0d_c%0d got=%b want=%b", f, k, got, exp_v[k]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bus2.overrun !== 1'b0) $display("FAIL dec1_overrun got=%b want=0", bus2.overrun);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt          = 0;
    total_cnt         = 0;
    reset             = 1'b1;
    bus4.sample_valid = 1'b0;
    bus4.sample_bit   = 1'b0;
    bus4.fb_bit       = 1'b0;
    bus2.sample_valid = 1'b0;
    bus2.sample_bit   = 1'b0;
    bus2.fb_bit       = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_decimation();
    test_back_to_back();
    test_overrun();
    test_reset_midpass();
    test_dec1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sd_filter_sched.md
Name: sd_filter_sched

Overview:
Sequencer that time-multiplexes one shared sd_filter_node-style accumulator datapath across N_STAGES cascaded filter stages.
- Each accepted modulator sample triggers one update pass over all stages. Stages are visited last-to-first, so in-place state storage keeps the "all nodes update on old values" semantics of a parallel cascade.
- It also produces the decimated output strobe and flags sample overrun.
- It sits between the modulator bit capture and the stage-state RAM plus shared node datapath.

Parameters:
N_STAGES, 4, number of filter stages sharing the datapath (>=2)
DEC, 16, decimation ratio in samples per dec_valid pulse (>=1)
SEL_W, $clog2(N_STAGES), width of stage_sel

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sample_valid  in  1  one-cycle strobe: new modulator sample present
sample_bit  in  1  modulator input bit (drives beta select)
fb_bit  in  1  quantizer feedback bit (drives alpha select)
ready  out  1  high when idle and able to accept sample_valid
stage_sel  out  SEL_W  stage index currently addressed (state RAM address, coefficient bank select)
stage_enb  out  1  accumulator write enable for stage_sel this cycle
stage_rsvd  out  1  latched sample_bit presented to the datapath
stage_fb  out  1  latched fb_bit presented to the datapath
frame_done  out  1  one-cycle pulse after the last stage (stage 0) is written
dec_valid  out  1  one-cycle pulse coincident with frame_done every DEC-th frame
overrun  out  1  sticky: sample_valid arrived while not ready

Behaviour:
- Reset values: ready=1, stage_sel=N_STAGES-1, stage_enb=0, stage_rsvd=0, stage_fb=0, frame_done=0, dec_valid=0, overrun=0. The decimation counter is cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - sample_valid=1 at edge t: latch sample_bit/fb_bit into stage_rsvd/stage_fb, set stage_sel=N_STAGES-1, go to RUN.
  - At t+1: ready=0, stage_enb=1.
- RUN:
  - stage_enb=1 every cycle.
  - stage_sel decrements by 1 per cycle: N_STAGES-1 down to 0. Exactly N_STAGES enable cycles.
  - When stage_sel==0 and stage_enb=1, next state is DONE.
  - stage_rsvd/stage_fb hold constant throughout RUN.
- DONE (one cycle):
  - stage_enb=0, frame_done=1, ready=0.
  - The decimation counter increments. If it was DEC-1, it wraps to 0 and dec_valid=1 in the same cycle.
  - Next state IDLE; stage_sel returns to N_STAGES-1.
- Latency: sample_valid to first stage_enb is 1 cycle. sample_valid to frame_done is N_STAGES+1 cycles. Back-to-back sample period minimum is N_STAGES+2 cycles.
- Overrun:
  - sample_valid while state != IDLE sets overrun=1. The sample is dropped; the current pass is unaffected.
  - overrun stays set until reset.
- DEC=1: dec_valid=1 on every frame_done.
- Reset mid-pass: all state returns to IDLE within the reset cycle. stage_enb is 0 from the cycle after reset is sampled. The partial pass is abandoned (datapath state is the owner's responsibility).
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- sd_filter_pkg gains:
  - typedef enum {SCHED_IDLE, SCHED_RUN, SCHED_DONE} sd_sched_state_t
  - a function returning the minimum sample period (N_STAGES+2), for benches and upstream rate checks.
- One natural sub-module: sd_dec_counter. Modulo-DEC counter with an increment strobe and a terminal-count pulse output; reused later for multi-rate cascades.

Test Plan:
- Reset then a single sample_valid with sample_bit=1, fb_bit=0 (N_STAGES=4) -> stage_enb high 4 cycles with stage_sel 3,2,1,0; stage_rsvd=1, stage_fb=0 throughout; frame_done at t+5; ready low t+1..t+5, high at t+6.
- 16 samples spaced 6 cycles apart (DEC=16) -> 16 frame_done pulses; dec_valid only on the 16th; overrun stays 0.
- sample_valid at t and again at t+2 -> second dropped; overrun=1 from t+3 and sticky; exactly 4 stage_enb cycles total.
- sample_valid exactly when ready returns high (period 6) -> accepted, no overrun, stage_sel restarts at 3.
- Assert reset while stage_sel=1 -> next cycle stage_enb=0, ready=1, stage_sel=3, overrun=0, no frame_done; the next sample runs a full pass.
- DEC=1, N_STAGES=2 -> every frame_done accompanied by dec_valid; stage_sel sequence 1,0; frame_done 3 cycles after sample_valid.
